// File: rtl/logicnets_input_packer.sv
// Quantizes a stream of signed readout samples and packs one frame of N_FEAT
// features into a registered bus for the layer-0 LogicNets neuron LUTs.
module logicnets_input_packer #(
    parameter int SAMPLE_W = 16,
    parameter int N_FEAT   = 64,
    parameter int QBITS    = 1,
    parameter int SHIFT    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_FEAT*QBITS-1:0]    m_data,
    output logic                       err_short,
    output logic                       err_long
);

    localparam int CW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int DW = N_FEAT * QBITS;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_FEAT - 1);
    localparam logic signed [SAMPLE_W:0] Q_OFFSET = (SAMPLE_W + 1)'(2 ** (QBITS - 1));
    localparam logic signed [SAMPLE_W:0] Q_MAX    = (SAMPLE_W + 1)'(2 ** QBITS - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    // One extra bit of headroom so the offset add can never wrap.
    function automatic logic [QBITS-1:0] quantize(input logic signed [SAMPLE_W-1:0] x);
        logic signed [SAMPLE_W:0] ext;
        logic signed [SAMPLE_W:0] v;
        ext = {x[SAMPLE_W-1], x};
        v   = (ext >>> SHIFT) + Q_OFFSET;
        if (v[SAMPLE_W]) begin
            quantize = '0;
        end else if (v > Q_MAX) begin
            quantize = '1;
        end else begin
            quantize = v[QBITS-1:0];
        end
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   data_q, data_d;
    logic            m_valid_q, m_valid_d;
    logic            err_short_q, err_short_d;
    logic            err_long_q, err_long_d;
    logic            accept;
    logic [QBITS-1:0] q;

    assign s_ready   = (state_q != HOLD);
    assign accept    = s_valid && s_ready;
    assign m_valid   = m_valid_q;
    assign m_data    = data_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        data_d      = data_q;
        m_valid_d   = m_valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        q           = quantize(s_data);

        case (state_q)
            FILL: begin
                if (accept) begin
                    data_d[int'(count_q) * QBITS +: QBITS] = q;
                    if (count_q == LAST_IDX) begin
                        if (s_last) begin
                            state_d   = HOLD;
                            m_valid_d = 1'b1;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = DROP;
                        end
                    end else if (s_last) begin
                        // Unwritten features are already zero from the last clear.
                        err_short_d = 1'b1;
                        state_d     = HOLD;
                        m_valid_d   = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_d   = HOLD;
                    m_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    data_d    = '0;
                    count_d   = '0;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            data_q      <= '0;
            m_valid_q   <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            data_q      <= data_d;
            m_valid_q   <= m_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

endmodule

// File: tb/tb_logicnets_input_packer.sv
// Scoreboard bench: a 64x1-bit packer and a 6x2-bit packer sharing clock/reset.
module tb_logicnets_input_packer;

    localparam logic [1:0] ERR_SHORT = 2'b10;
    localparam logic [1:0] ERR_LONG  = 2'b01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               s_valid_a, s_ready_a, s_last_a, m_valid_a, m_ready_a;
    logic signed [15:0] s_data_a;
    logic [63:0]        m_data_a;
    logic               err_short_a, err_long_a;

    logic               s_valid_b, s_ready_b, s_last_b, m_valid_b, m_ready_b;
    logic signed [15:0] s_data_b;
    logic [11:0]        m_data_b;
    logic               err_short_b, err_long_b;

    logicnets_input_packer #(.SAMPLE_W(16), .N_FEAT(64), .QBITS(1), .SHIFT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a), .s_last(s_last_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
        .err_short(err_short_a), .err_long(err_long_a)
    );

    logicnets_input_packer #(.SAMPLE_W(16), .N_FEAT(6), .QBITS(2), .SHIFT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_last(s_last_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
        .err_short(err_short_b), .err_long(err_long_b)
    );

    int total = 0;
    int bad = 0;

    logic [63:0] exp_a_q[$];
    logic [1:0]  err_a_q[$];
    logic [11:0] exp_b_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitors: pop on every output handshake or error pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid_a && m_ready_a) begin
                if (exp_a_q.size() == 0) fail_now("a_frame_unexpected");
                else chk("a_frame", m_data_a, exp_a_q.pop_front());
            end
            if (err_short_a || err_long_a) begin
                if (err_a_q.size() == 0) fail_now("a_err_unexpected");
                else chk("a_err", {62'd0, err_short_a, err_long_a}, {62'd0, err_a_q.pop_front()});
            end
            if (m_valid_b && m_ready_b) begin
                if (exp_b_q.size() == 0) fail_now("b_frame_unexpected");
                else chk("b_frame", {52'd0, m_data_b}, {52'd0, exp_b_q.pop_front()});
            end
            if (err_short_b || err_long_b) fail_now("b_err_unexpected");
        end
    end

    task automatic send_a(input logic signed [15:0] d, input logic l);
        int n = 0;
        s_valid_a = 1'b1;
        s_data_a  = d;
        s_last_a  = l;
        @(negedge clk);
        while (!s_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_a) fail_now("a_send_timeout");
        @(posedge clk);
        #1;
        s_valid_a = 1'b0;
        s_last_a  = 1'b0;
    endtask

    task automatic send_b(input logic signed [15:0] d, input logic l);
        int n = 0;
        s_valid_b = 1'b1;
        s_data_b  = d;
        s_last_b  = l;
        @(negedge clk);
        while (!s_ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready_b) fail_now("b_send_timeout");
        @(posedge clk);
        #1;
        s_valid_b = 1'b0;
        s_last_b  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid_a = 1'b0; s_data_a = '0; s_last_a = 1'b0; m_ready_a = 1'b0;
        s_valid_b = 1'b0; s_data_b = '0; s_last_b = 1'b0; m_ready_b = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_m_valid", m_valid_a, 0);
        chk("rst_m_data", m_data_a, 0);
        chk("rst_err", {err_short_a, err_long_a}, 0);
        chk("rst_s_ready", s_ready_a, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Alternating +100/-100: even features 1, odd features 0.
        exp_a_q.push_back(64'h5555_5555_5555_5555);
        for (int i = 0; i < 64; i++) send_a((i % 2 == 0) ? 16'sd100 : -16'sd100, i == 63);
        chk("latency_m_valid", m_valid_a, 1);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("stall_m_valid", m_valid_a, 1);
            chk("stall_m_data", m_data_a, 64'h5555_5555_5555_5555);
            chk("stall_s_ready", s_ready_a, 0);
        end
        m_ready_a = 1'b1;
        @(posedge clk);
        #1;
        chk("release_s_ready", s_ready_a, 1);
        chk("release_m_valid", m_valid_a, 0);
        chk("release_m_data_cleared", m_data_a, 0);

        // Short frame of 5 positive samples.
        exp_a_q.push_back(64'h0000_0000_0000_001F);
        err_a_q.push_back(ERR_SHORT);
        for (int i = 0; i < 5; i++) send_a(16'sd1, i == 4);
        chk("short_err_pulse", err_short_a, 1);
        chk("short_m_valid", m_valid_a, 1);
        @(posedge clk);
        #1;
        chk("short_err_one_cycle", err_short_a, 0);

        // Long frame: 32 positive, then negative; samples 65..70 must be dropped.
        exp_a_q.push_back(64'h0000_0000_FFFF_FFFF);
        err_a_q.push_back(ERR_LONG);
        for (int i = 0; i < 70; i++) begin
            send_a((i < 32) ? 16'sd200 : -16'sd200, i == 69);
            if (i == 63) begin
                chk("long_err_pulse", err_long_a, 1);
                chk("long_no_valid_in_drop", m_valid_a, 0);
            end
            if (i == 64) chk("long_err_one_cycle", err_long_a, 0);
        end
        chk("long_m_valid", m_valid_a, 1);

        // 2-bit quantizer: (x>>>4)+2 clamped to 0..3.
        // -32768->0, -17->0, -16->1, 15->2, 16->3, 32767->3
        exp_b_q.push_back(12'hF90);
        send_b(16'sh8000, 1'b0);
        send_b(-16'sd17, 1'b0);
        send_b(-16'sd16, 1'b0);
        send_b(16'sd15, 1'b0);
        send_b(16'sd16, 1'b0);
        send_b(16'sd32767, 1'b1);
        chk("b_latency_m_valid", m_valid_b, 1);
        // 0->2, -1->1, 31->3, -33->0, 100->3, -100->0
        exp_b_q.push_back(12'h336);
        send_b(16'sd0, 1'b0);
        send_b(-16'sd1, 1'b0);
        send_b(16'sd31, 1'b0);
        send_b(-16'sd33, 1'b0);
        send_b(16'sd100, 1'b0);
        send_b(-16'sd100, 1'b1);
        chk("b2_latency_m_valid", m_valid_b, 1);
        @(posedge clk);
        #1;

        // Async reset in the middle of a frame.
        for (int i = 0; i < 30; i++) send_a(16'sd50, 1'b0);
        chk("partial_pack", m_data_a, 64'h0000_0000_3FFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", m_valid_a, 0);
        chk("async_rst_m_data", m_data_a, 0);
        chk("async_rst_s_ready", s_ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        exp_a_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        for (int i = 0; i < 64; i++) send_a((i % 2 == 0) ? -16'sd100 : 16'sd100, i == 63);
        chk("post_rst_m_valid", m_valid_a, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("a_frames_left", exp_a_q.size(), 0);
        chk("a_errs_left", err_a_q.size(), 0);
        chk("b_frames_left", exp_b_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
